// File: rtl/float_div_seq_pkg.sv
// ============================================================================
// Module      : float_div_seq_pkg
// Description : Shared FSM states and format constants for float_div_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package float_div_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_NORM = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic int unsigned c_bias(input int unsigned e);
        return (32'd1 << (e - 1)) - 32'd1;
    endfunction

    // Packed {sign=0, exp=all-ones, mant=0}; callers truncate to 1+E+M bits.
    function automatic logic [63:0] c_inf_bits(input int unsigned e, input int unsigned m);
        return ((64'd1 << e) - 64'd1) << m;
    endfunction

    function automatic logic [63:0] c_qnan_bits(input int unsigned e, input int unsigned m);
        return c_inf_bits(e, m) | (64'd1 << (m - 1));
    endfunction

endpackage

`default_nettype wire

// File: rtl/float_div_seq_if.sv
// ============================================================================
// Module      : float_div_seq_if
// Description : Operand/result handshake bundle for float_div_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface float_div_seq_if #(
    parameter int E = 8,
    parameter int M = 23
);
    localparam int W = 1 + E + M;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] q;
    logic [3:0]   flags;

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, q, flags
    );

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, q, flags
    );
endinterface

`default_nettype wire

// File: rtl/float_div_special.sv
// ============================================================================
// Module      : float_div_special
// Description : Classifies operands (zero/Inf/NaN) and forms special results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module float_div_special
    import float_div_seq_pkg::*;
#(
    parameter int E = 8,
    parameter int M = 23
) (
    input  wire logic [E+M:0] i_a,
    input  wire logic [E+M:0] i_b,
    output logic              o_special,
    output logic [E+M:0]      o_q,
    output logic [3:0]        o_flags
);
    localparam int W = 1 + E + M;
    localparam logic [W-1:0] c_inf  = W'(c_inf_bits(E, M));
    localparam logic [W-1:0] c_qnan = W'(c_qnan_bits(E, M));

    logic w_sign;
    logic w_a_zero, w_a_inf, w_a_nan;
    logic w_b_zero, w_b_inf, w_b_nan;

    // Denormals share exponent 0 with zero and are flushed with it.
    assign w_sign   = i_a[W-1] ^ i_b[W-1];
    assign w_a_zero = (i_a[W-2:M] == '0);
    assign w_b_zero = (i_b[W-2:M] == '0);
    assign w_a_inf  = (&i_a[W-2:M]) && (i_a[M-1:0] == '0);
    assign w_b_inf  = (&i_b[W-2:M]) && (i_b[M-1:0] == '0);
    assign w_a_nan  = (&i_a[W-2:M]) && (i_a[M-1:0] != '0);
    assign w_b_nan  = (&i_b[W-2:M]) && (i_b[M-1:0] != '0);

    always_comb begin
        o_special = 1'b1;
        o_q       = '0;
        o_flags   = 4'b0000;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            o_q     = c_qnan;
            o_flags = 4'b1000;
        end else if (w_a_inf) begin
            o_q = {w_sign, c_inf[W-2:0]};
        end else if (w_b_zero) begin
            o_q     = {w_sign, c_inf[W-2:0]};
            o_flags = 4'b0100;
        end else if (w_a_zero || w_b_inf) begin
            o_q = {w_sign, {(W-1){1'b0}}};
        end else begin
            o_special = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/float_div_seq.sv
// ============================================================================
// Module      : float_div_seq
// Description : Sequential restoring-division floating-point divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module float_div_seq
    import float_div_seq_pkg::*;
#(
    parameter int E = 8,
    parameter int M = 23
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    float_div_seq_if.slave bus
);
    localparam int W  = 1 + E + M;
    localparam int CW = $clog2(M + 2);
    localparam logic [W-1:0]        c_inf      = W'(c_inf_bits(E, M));
    localparam logic signed [E+1:0] c_bias_x   = (E+2)'(c_bias(E));
    localparam logic signed [E+1:0] c_exp_max  = (E+2)'((1 << E) - 1);
    localparam logic [CW-1:0]       c_last_cnt = CW'(M + 1);

    state_t                r_state_q, w_state_d;
    logic                  r_sign_q, w_sign_d;
    logic signed [E+1:0]   r_exp_q, w_exp_d;
    logic [M+1:0]          r_rem_q, w_rem_d;
    logic [M:0]            r_div_q, w_div_d;
    logic [M+1:0]          r_quo_q, w_quo_d;
    logic [CW-1:0]         r_cnt_q, w_cnt_d;
    logic [W-1:0]          r_q_q, w_q_d;
    logic [3:0]            r_flags_q, w_flags_d;
    logic                  r_in_ready_q, w_in_ready_d;
    logic                  r_out_valid_q, w_out_valid_d;

    logic                  w_sp_special;
    logic [W-1:0]          w_sp_q;
    logic [3:0]            w_sp_flags;

    float_div_special #(.E(E), .M(M)) u_special (
        .i_a       (bus.a),
        .i_b       (bus.b),
        .o_special (w_sp_special),
        .o_q       (w_sp_q),
        .o_flags   (w_sp_flags)
    );

    logic signed [E+1:0] w_exp_cap;
    logic                w_ge;
    logic [M:0]          w_diff;
    logic [M:0]          w_rem_next;
    logic signed [E+1:0] w_exp_adj;
    logic [M-1:0]        w_mant;

    assign w_exp_cap = $signed({2'b00, bus.a[W-2:M]}) - $signed({2'b00, bus.b[W-2:M]}) + c_bias_x;

    // A kept remainder is always below the divisor, so M+1 bits of difference suffice.
    assign w_ge       = (r_rem_q >= {1'b0, r_div_q});
    assign w_diff     = r_rem_q[M:0] - r_div_q;
    assign w_rem_next = w_ge ? w_diff : r_rem_q[M:0];

    assign w_exp_adj = r_exp_q - $signed({{(E+1){1'b0}}, ~r_quo_q[M+1]});
    assign w_mant    = r_quo_q[M+1] ? r_quo_q[M:1] : r_quo_q[M-1:0];

    always_comb begin
        w_state_d     = r_state_q;
        w_sign_d      = r_sign_q;
        w_exp_d       = r_exp_q;
        w_rem_d       = r_rem_q;
        w_div_d       = r_div_q;
        w_quo_d       = r_quo_q;
        w_cnt_d       = r_cnt_q;
        w_q_d         = r_q_q;
        w_flags_d     = r_flags_q;
        w_in_ready_d  = r_in_ready_q;
        w_out_valid_d = r_out_valid_q;
        case (r_state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_in_ready_d = 1'b0;
                    if (w_sp_special) begin
                        w_q_d         = w_sp_q;
                        w_flags_d     = w_sp_flags;
                        w_out_valid_d = 1'b1;
                        w_state_d     = ST_DONE;
                    end else begin
                        w_sign_d  = bus.a[W-1] ^ bus.b[W-1];
                        w_exp_d   = w_exp_cap;
                        w_rem_d   = {2'b01, bus.a[M-1:0]};
                        w_div_d   = {1'b1, bus.b[M-1:0]};
                        w_quo_d   = '0;
                        w_cnt_d   = '0;
                        w_state_d = ST_DIV;
                    end
                end
            end
            ST_DIV: begin
                w_quo_d = {r_quo_q[M:0], w_ge};
                w_rem_d = {w_rem_next, 1'b0};
                w_cnt_d = r_cnt_q + 1'b1;
                if (r_cnt_q == c_last_cnt) begin
                    w_state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                if (w_exp_adj >= c_exp_max) begin
                    w_q_d     = {r_sign_q, c_inf[W-2:0]};
                    w_flags_d = 4'b0010;
                end else if (w_exp_adj[E+1] || (w_exp_adj == '0)) begin
                    w_q_d     = {r_sign_q, {(W-1){1'b0}}};
                    w_flags_d = 4'b0001;
                end else begin
                    w_q_d     = {r_sign_q, w_exp_adj[E-1:0], w_mant};
                    w_flags_d = 4'b0000;
                end
                w_out_valid_d = 1'b1;
                w_state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    w_out_valid_d = 1'b0;
                    w_in_ready_d  = 1'b1;
                    w_state_d     = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q     <= ST_IDLE;
            r_sign_q      <= 1'b0;
            r_exp_q       <= '0;
            r_rem_q       <= '0;
            r_div_q       <= '0;
            r_quo_q       <= '0;
            r_cnt_q       <= '0;
            r_q_q         <= '0;
            r_flags_q     <= '0;
            r_in_ready_q  <= 1'b1;
            r_out_valid_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_sign_q      <= w_sign_d;
            r_exp_q       <= w_exp_d;
            r_rem_q       <= w_rem_d;
            r_div_q       <= w_div_d;
            r_quo_q       <= w_quo_d;
            r_cnt_q       <= w_cnt_d;
            r_q_q         <= w_q_d;
            r_flags_q     <= w_flags_d;
            r_in_ready_q  <= w_in_ready_d;
            r_out_valid_q <= w_out_valid_d;
        end
    end

    assign bus.in_ready  = r_in_ready_q;
    assign bus.out_valid = r_out_valid_q;
    assign bus.q         = r_q_q;
    assign bus.flags     = r_flags_q;

endmodule

`default_nettype wire

// File: tb/tb_float_div_seq.sv
// ============================================================================
// Module      : tb_float_div_seq
// Description : Directed-vector self-checking bench for float_div_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_float_div_seq;

    logic clk;
    logic rst_n;

    float_div_seq_if #(.E(8), .M(23)) bus ();

    float_div_seq #(.E(8), .M(23)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [3:0]  fl;
        int          lat;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    int n_vec;
    int n_bad;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Issues one operation; returns the result and the cycle count from the capture cycle.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [3:0] fl, output int lat);
        @(negedge clk);
        check("in_ready_before", {31'd0, bus.in_ready}, 32'd1);
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        q  = bus.q;
        fl = bus.flags;
    endtask

    task automatic finish_op();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("in_ready_after", {31'd0, bus.in_ready}, 32'd1);
        check("out_valid_after", {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        logic [31:0] q;
        logic [3:0]  fl;
        int          lat;
        logic [31:0] q_hold;
        logic [3:0]  fl_hold;
        bit          seen;

        n_vec = 0;
        n_bad = 0;

        vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27};
        vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 27};
        vecs[2]  = '{32'h3F800000, 32'h80000000, 32'hFF800000, 4'b0100, 1};
        vecs[3]  = '{32'h7F000000, 32'h00800000, 32'h7F800000, 4'b0010, 27};
        vecs[4]  = '{32'h00800000, 32'h7F000000, 32'h00000000, 4'b0001, 27};
        vecs[5]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1};
        vecs[6]  = '{32'h00000000, 32'h80000000, 32'h7FC00000, 4'b1000, 1};
        vecs[7]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, 1};
        vecs[8]  = '{32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000, 1};
        vecs[9]  = '{32'h80000000, 32'h40A00000, 32'h80000000, 4'b0000, 1};
        vecs[10] = '{32'h40400000, 32'hFF800000, 32'h80000000, 4'b0000, 1};
        vecs[11] = '{32'hC1000000, 32'h40000000, 32'hC0800000, 4'b0000, 27};
        vecs[12] = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 27};
        vecs[13] = '{32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000, 1};
        vecs[14] = '{32'hC0C00000, 32'hC0000000, 32'h40400000, 4'b0000, 27};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        rst_n         = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_q", bus.q, 32'd0);
        check("rst_flags", {28'd0, bus.flags}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            n_vec++;
            run_op(vecs[i].a, vecs[i].b, q, fl, lat);
            check($sformatf("v%0d_q", i), q, vecs[i].q);
            check($sformatf("v%0d_flags", i), {28'd0, fl}, {28'd0, vecs[i].fl});
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            finish_op();
        end

        // Stall in DONE: result must hold, new operands and in_ready must stay off.
        n_vec++;
        run_op(32'h40C00000, 32'h40000000, q_hold, fl_hold, lat);
        check("stall_q0", q_hold, 32'h40400000);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.a        = 32'h3F800000;
            bus.b        = 32'h80000000;
            @(posedge clk);
            #1;
            check("stall_q", bus.q, q_hold);
            check("stall_flags", {28'd0, bus.flags}, {28'd0, fl_hold});
            check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
            check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.in_valid = 1'b0;
        finish_op();

        // out_ready asserted during DIV must not complete anything early.
        n_vec++;
        bus.out_ready = 1'b1;
        run_op(32'h3F800000, 32'h3F800000, q, fl, lat);
        check("ordy_early_q", q, 32'h3F800000);
        check("ordy_early_lat", lat, 27);
        bus.out_ready = 1'b0;
        finish_op();

        // Reset asserted in the middle of DIV aborts the operation.
        n_vec++;
        @(negedge clk);
        bus.a        = 32'h40C00000;
        bus.b        = 32'h40000000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("abort_q", bus.q, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen = 1'b1;
        end
        check("abort_no_result", {31'd0, seen}, 32'd0);
        n_vec++;
        run_op(32'h40C00000, 32'h40000000, q, fl, lat);
        check("post_abort_q", q, 32'h40400000);
        check("post_abort_flags", {28'd0, fl}, 32'd0);
        check("post_abort_lat", lat, 27);
        finish_op();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
